// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state and ALUOp encodings for the 16-bit processor control path.
// The single-cycle decoder and the multi-cycle unit both draw their opcode constants from here.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LW   = 4'h1;
    localparam logic [3:0] OP_SW   = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       pc_write;
        logic       ir_write;
        logic       illegal;
        logic       bus_error;
        logic       halted;
        logic       retire;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational control-output map: (state, opcode, zero, mem_ready, timeout) -> datapath strobes.
// Also produces the internal retire strobe that advances the retired-instruction counter.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       legal,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       timeout,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end else if (timeout) begin
                    ctrl.bus_error = 1'b1;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    ctrl.illegal = 1'b1;
                end else if (op == OP_J) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.retire   = 1'b1;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_R: ctrl.alu_op = ALU_FUNCT;
                    OP_LW, OP_SW, OP_ADDI: begin
                        ctrl.alu_op  = ALU_ADD;
                        ctrl.alu_src = 1'b1;
                    end
                    OP_BEQ: begin
                        ctrl.alu_op   = ALU_SUB;
                        ctrl.branch   = 1'b1;
                        ctrl.pc_write = zero;
                        ctrl.retire   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (op == OP_LW) ctrl.mem_read = 1'b1;
                if (op == OP_SW) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.retire    = mem_ready;
                end
                if (!mem_ready && timeout) ctrl.bus_error = 1'b1;
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
                ctrl.reg_dst    = (op == OP_R);
                ctrl.mem_to_reg = (op == OP_LW);
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bounded memory wait and retire counter.
// Holds the state register, latched opcode, wait counter and retired count; outputs are decoded combinationally.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                RegDst,
    output logic                Branch,
    output logic                MemRead,
    output logic                MemtoReg,
    output logic                MemWrite,
    output logic                ALUSrc,
    output logic                RegWrite,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                pc_write,
    output logic                ir_write,
    output logic                illegal,
    output logic                bus_error,
    output logic                halted,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    retired
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, cur_op;
    logic [WCW-1:0]      wait_q, wait_d;
    logic                legal, waitable, timeout;
    ctrl_t               ctrl, ctrl_g;

    // DECODE acts on the live opcode; later states use the copy latched on leaving DECODE.
    assign cur_op   = (state_q == S_DECODE) ? opcode : op_q;
    assign legal    = ((cur_op >> 4) == '0) && op_legal(cur_op[3:0]);
    assign waitable = (state_q == S_FETCH) || (state_q == S_MEM);
    // Timeout fires in the MEM_TIMEOUT-th cycle spent in the state; ready in that cycle still wins.
    assign timeout  = waitable && (wait_q == WCW'(MEM_TIMEOUT - 1));
    assign wait_d   = (waitable && !mem_ready && !timeout) ? wait_q + 1'b1 : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) op_q <= opcode;
            if (ctrl.retire) retired <= retired + 1'b1;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!legal)                      state_d = S_FETCH;
                else if (cur_op[3:0] == OP_HALT) state_d = S_HALT;
                else if (cur_op[3:0] == OP_J)    state_d = S_FETCH;
                else                             state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cur_op[3:0])
                    OP_R, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:  state_d = S_MEM;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)    state_d = (cur_op[3:0] == OP_LW) ? S_WB : S_FETCH;
                else if (timeout) state_d = S_FETCH;
                else              state_d = S_MEM;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    ctrl_output_decode u_dec (
        .state     (state_q),
        .op        (cur_op[3:0]),
        .legal     (legal),
        .zero      (zero),
        .mem_ready (mem_ready),
        .timeout   (timeout),
        .ctrl      (ctrl)
    );

    assign ctrl_g    = reset_n ? ctrl : '0;
    assign RegDst    = ctrl_g.reg_dst;
    assign Branch    = ctrl_g.branch;
    assign MemRead   = ctrl_g.mem_read;
    assign MemtoReg  = ctrl_g.mem_to_reg;
    assign MemWrite  = ctrl_g.mem_write;
    assign ALUSrc    = ctrl_g.alu_src;
    assign RegWrite  = ctrl_g.reg_write;
    assign ALUOp     = ALUOP_W'(ctrl_g.alu_op);
    assign pc_write  = ctrl_g.pc_write;
    assign ir_write  = ctrl_g.ir_write;
    assign illegal   = ctrl_g.illegal;
    assign bus_error = ctrl_g.bus_error;
    assign halted    = ctrl_g.halted;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction walks, stalls, timeout, illegal, halt, reset, wrap.
module tb_multicycle_control_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] opcode;
    logic       zero, mem_ready;
    logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0] ALUOp;
    logic       pc_write, ir_write, illegal, bus_error, halted;
    logic [2:0] state;
    logic [1:0] retired;

    int errors = 0;
    int checks = 0;

    multicycle_control_unit #(
        .OPCODE_W(4), .ALUOP_W(2), .MEM_TIMEOUT(15), .CNT_W(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .pc_write(pc_write), .ir_write(ir_write), .illegal(illegal), .bus_error(bus_error),
        .halted(halted), .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
        #3;
        chk("rst_state", state, 0);
        chk("rst_retired", retired, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_irwrite", ir_write, 0);
        #9;
        // LW with mem_ready held high: 0,1,2,3,4,0
        reset_n = 1'b1; opcode = 4'h1; mem_ready = 1'b1;
        #1;
        chk("lw_f_state", state, 0);
        chk("lw_f_memread", MemRead, 1);
        chk("lw_f_irwrite", ir_write, 1);
        chk("lw_f_pcwrite", pc_write, 1);
        tick();
        chk("lw_d_state", state, 1);
        chk("lw_d_memread", MemRead, 0);
        tick();
        chk("lw_e_state", state, 2);
        chk("lw_e_alusrc", ALUSrc, 1);
        chk("lw_e_aluop", ALUOp, 0);
        tick();
        chk("lw_m_state", state, 3);
        chk("lw_m_memread", MemRead, 1);
        tick();
        chk("lw_w_state", state, 4);
        chk("lw_w_memtoreg", MemtoReg, 1);
        chk("lw_w_regwrite", RegWrite, 1);
        chk("lw_w_regdst", RegDst, 0);
        chk("lw_w_retired", retired, 0);
        tick();
        chk("lw_done_state", state, 0);
        chk("lw_done_retired", retired, 1);

        // BEQ taken then not taken
        opcode = 4'h3; zero = 1'b1;
        tick(); tick();
        chk("beq1_state", state, 2);
        chk("beq1_branch", Branch, 1);
        chk("beq1_aluop", ALUOp, 1);
        chk("beq1_pcwrite", pc_write, 1);
        tick();
        chk("beq1_done", state, 0);
        chk("beq1_retired", retired, 2);
        zero = 1'b0;
        tick(); tick();
        chk("beq0_branch", Branch, 1);
        chk("beq0_pcwrite", pc_write, 0);
        tick();
        chk("beq0_retired", retired, 3);

        // SW stalling three cycles in MEM; its retire wraps the 2-bit counter
        opcode = 4'h2;
        tick(); tick();
        chk("sw_e_state", state, 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_wait_state", state, 3);
            chk("sw_wait_memwrite", MemWrite, 1);
            chk("sw_wait_regwrite", RegWrite, 0);
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_rdy_memwrite", MemWrite, 1);
        tick();
        chk("sw_done_state", state, 0);
        chk("wrap_retired", retired, 0);

        // LW with mem_ready never arriving in MEM: bus_error on 15th cycle
        opcode = 4'h1;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 1; i < 15; i++) begin
            chk("to_wait_state", state, 3);
            chk("to_wait_buserr", bus_error, 0);
            tick();
        end
        chk("to_state", state, 3);
        chk("to_buserr", bus_error, 1);
        tick();
        chk("to_done_state", state, 0);
        chk("to_done_buserr", bus_error, 0);
        chk("to_retired", retired, 0);
        mem_ready = 1'b1;

        // Same, but ready arrives on the 15th cycle: ready wins
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        for (int i = 1; i < 15; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("rdy15_state", state, 3);
        chk("rdy15_buserr", bus_error, 0);
        tick();
        chk("rdy15_wb", state, 4);
        tick();
        chk("rdy15_retired", retired, 1);

        // Illegal opcode
        opcode = 4'h7;
        tick();
        chk("ill_state", state, 1);
        chk("ill_pulse", illegal, 1);
        tick();
        chk("ill_done_state", state, 0);
        chk("ill_done_pulse", illegal, 0);
        chk("ill_retired", retired, 1);

        // Jump
        opcode = 4'h5;
        tick();
        chk("j_pcwrite", pc_write, 1);
        tick();
        chk("j_state", state, 0);
        chk("j_retired", retired, 2);

        // R-type aborted by reset during WB
        opcode = 4'h0;
        tick(); tick();
        chk("r_aluop", ALUOp, 2);
        tick();
        chk("r_wb_state", state, 4);
        chk("r_wb_regwrite", RegWrite, 1);
        chk("r_wb_regdst", RegDst, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_wb_regwrite", RegWrite, 0);
        chk("rst_wb_state", state, 0);
        chk("rst_wb_retired", retired, 0);
        opcode = 4'hF;
        reset_n = 1'b1;
        #1;
        chk("rel_state", state, 0);

        // HALT is sticky
        tick();
        chk("h_decode", state, 1);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("h_state", state, 5);
            chk("h_halted", halted, 1);
            chk("h_memread", MemRead, 0);
            tick();
        end
        chk("h_retired", retired, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
